// File: rtl/tracker_axis_sequencer.sv
// Tracker axis sequencer: positions the teta (vertical) axis first, lets it
// settle, then positions the fi (horizontal) axis. Only one motor is ever
// driven at a time. Owns the deadband, settle-time and per-axis timeout policy.
module tracker_axis_sequencer #(
    parameter int W           = 16,
    parameter int ERROR       = 4,
    parameter int FULL_TURN   = 360,
    parameter int SETTLE_CYC  = 1000,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic         abort,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] C,
    input  logic [W-1:0] D,
    input  logic [W-1:0] teta_d,
    input  logic [W-1:0] teta_actual,
    input  logic [W-1:0] fi_d,
    input  logic [W-1:0] fi_actual,
    output logic [1:0]   S_out_teta,
    output logic [1:0]   S_out_fi,
    output logic         busy,
    output logic         done,
    output logic         timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_MOVE_T, S_SETTLE_T, S_MOVE_F, S_SETTLE_F, S_DONE, S_FAULT
    } state_t;

    localparam int SET_W = $clog2(SETTLE_CYC) + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMER_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [W:0]       FULL_W      = (W+1)'(FULL_TURN);
    localparam logic [W:0]       ERR_W       = (W+1)'(ERROR);

    state_t           state, state_nxt;
    logic [SET_W-1:0] settle_cnt, settle_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             mode_q, mode_nxt, terr_nxt;
    logic [1:0]       teta_nxt, fi_nxt;
    logic             busy_nxt, done_nxt;
    logic             idle_like, eff_mode;
    logic             bad_t, bad_f, range_fault;
    logic [1:0]       dir_t, dir_f;
    logic             in_t, in_f;

    // Sensor-pair balance: direction that shrinks |x-y|, 00 inside the deadband.
    function automatic logic [1:0] auto_dir(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] mag;
        if (x >= y) mag = {1'b0, x} - {1'b0, y};
        else        mag = {1'b0, y} - {1'b0, x};
        if (mag < ERR_W) return 2'b00;
        return (x < y) ? 2'b01 : 2'b10;
    endfunction

    // Shortest wrapped path from act to des; a tie resolves to the negative direction.
    function automatic logic [1:0] manual_dir(input logic [W-1:0] act, input logic [W-1:0] des);
        logic [W:0] d1, d2, dmin;
        if (act >= des) d1 = {1'b0, act} - {1'b0, des};
        else            d1 = {1'b0, act} + FULL_W - {1'b0, des};
        d2   = (d1 == '0) ? '0 : FULL_W - d1;
        dmin = (d1 < d2) ? d1 : d2;
        if (dmin < ERR_W) return 2'b00;
        return (d1 > d2) ? 2'b01 : 2'b10;
    endfunction

    // Per-axis error evaluation; out-of-range manual angles never produce drive.
    always_comb begin
        idle_like   = (state == S_IDLE) || (state == S_DONE) || (state == S_FAULT);
        eff_mode    = idle_like ? mode : mode_q;
        bad_t       = ({1'b0, teta_actual} >= FULL_W) || ({1'b0, teta_d} >= FULL_W);
        bad_f       = ({1'b0, fi_actual} >= FULL_W) || ({1'b0, fi_d} >= FULL_W);
        dir_t       = eff_mode ? (bad_t ? 2'b00 : manual_dir(teta_actual, teta_d)) : auto_dir(C, D);
        dir_f       = eff_mode ? (bad_f ? 2'b00 : manual_dir(fi_actual, fi_d)) : auto_dir(A, B);
        in_t        = (dir_t == 2'b00);
        in_f        = (dir_f == 2'b00);
        range_fault = mode_q && (((state == S_MOVE_T || state == S_SETTLE_T) && bad_t) ||
                                 ((state == S_MOVE_F || state == S_SETTLE_F) && bad_f));
    end

    // State register together with counters and the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            settle_cnt  <= '0;
            timer       <= '0;
            mode_q      <= 1'b0;
            timeout_err <= 1'b0;
            S_out_teta  <= 2'b00;
            S_out_fi    <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            settle_cnt  <= settle_nxt;
            timer       <= timer_nxt;
            mode_q      <= mode_nxt;
            timeout_err <= terr_nxt;
            S_out_teta  <= teta_nxt;
            S_out_fi    <= fi_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    // Next-state logic: abort first, then range/timeout faults, then axis progress.
    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        timer_nxt  = timer;
        mode_nxt   = mode_q;
        terr_nxt   = timeout_err;
        if (abort) begin
            state_nxt = S_IDLE;
        end else if (idle_like) begin
            if (start) begin
                state_nxt  = S_MOVE_T;
                mode_nxt   = mode;
                terr_nxt   = 1'b0;
                settle_nxt = '0;
                timer_nxt  = '0;
            end else if (state == S_DONE) begin
                state_nxt = S_IDLE;
            end
        end else if (range_fault || timer == TIMER_LAST) begin
            state_nxt = S_FAULT;
            terr_nxt  = 1'b1;
        end else begin
            timer_nxt = timer + TMR_W'(1);
            case (state)
                S_MOVE_T: if (in_t) begin
                    state_nxt  = S_SETTLE_T;
                    settle_nxt = '0;
                end
                S_SETTLE_T: if (!in_t) begin
                    state_nxt  = S_MOVE_T;
                    settle_nxt = '0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt  = S_MOVE_F;
                    settle_nxt = '0;
                    timer_nxt  = '0;
                end else begin
                    settle_nxt = settle_cnt + SET_W'(1);
                end
                S_MOVE_F: if (in_f) begin
                    state_nxt  = S_SETTLE_F;
                    settle_nxt = '0;
                end
                S_SETTLE_F: if (!in_f) begin
                    state_nxt  = S_MOVE_F;
                    settle_nxt = '0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt  = S_DONE;
                    settle_nxt = '0;
                end else begin
                    settle_nxt = settle_cnt + SET_W'(1);
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state: only the moving axis gets drive.
    always_comb begin
        teta_nxt = (state_nxt == S_MOVE_T) ? dir_t : 2'b00;
        fi_nxt   = (state_nxt == S_MOVE_F) ? dir_f : 2'b00;
        busy_nxt = (state_nxt == S_MOVE_T) || (state_nxt == S_SETTLE_T) ||
                   (state_nxt == S_MOVE_F) || (state_nxt == S_SETTLE_F);
        done_nxt = (state_nxt == S_DONE);
    end

endmodule
